// File: rtl/addsub_serial.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : Single-bit full adder cell, chained to form one digit slice
//                of the serial adder-subtractor.
//  Ports       : a_i, b_i, ci_i  - addend bits and carry in
//                s_o, co_o       - sum bit and carry out
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

// ============================================================================
//  Module      : addsub_serial
//  Description : Digit-serial adder-subtractor with start/done handshake.
//                Computes a+b+ci (sub=0) or a-b-ci (sub=1) as
//                a + (b ^ {sub}) + (ci ^ sub), DIGIT bits per clock, LSB
//                digit first, over NDIG = WIDTH/DIGIT clocks.
//                Optional saturation is enabled by defining ADDSUB_SAT_EN.
//  Parameters  : WIDTH  - operand/result width (>= 2)
//                DIGIT  - bits per clock, must divide WIDTH
//  Ports       : clk, rst (async, active-high)
//                start_i       - request, sampled only while idle
//                a_i, b_i      - operands, captured on accepted start
//                ci_i, sub_i   - carry/borrow in and operation select
//                sat_i         - saturate request (ADDSUB_SAT_EN only)
//                busy_o        - operation in progress
//                done_o        - one-cycle pulse, result updated
//                s_o           - result, held until next done
//                co_o          - raw carry out of the MSB
//                ov_o          - signed overflow (raw)
//                zero_o        - presented result equals zero
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ci_i,
    input  logic             sub_i,
    input  logic             sat_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] s_o,
    output logic             co_o,
    output logic             ov_o,
    output logic             zero_o
);
    localparam int c_NDIG  = WIDTH / DIGIT;
    localparam int c_CNT_W = (c_NDIG > 1) ? $clog2(c_NDIG) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_NDIG - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;        // holds b already inverted for subtract
    logic               carry_q, carry_d;
    logic               sat_q, sat_d;
    logic [WIDTH-1:0]   acc_q, acc_d;    // partial sum, filled from the top
    logic               done_q, done_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               co_q, co_d;
    logic               ov_q, ov_d;
    logic               zero_q, zero_d;

    // One digit slice of full adders; operands are shifted so the active
    // digit always sits in the low DIGIT bits.
    logic [DIGIT:0]           w_carry;
    logic [DIGIT-1:0]         w_sum;
    logic [WIDTH+DIGIT-1:0]   w_cat;
    logic [WIDTH-1:0]         w_acc_next;
    logic                     w_ov;
    logic [WIDTH-1:0]         w_final;

    assign w_carry[0] = carry_q;

    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
        full_adder u_fa (
            .a_i  (a_q[gi]),
            .b_i  (b_q[gi]),
            .ci_i (w_carry[gi]),
            .s_o  (w_sum[gi]),
            .co_o (w_carry[gi+1])
        );
    end

    // New digit enters at the top; after NDIG shifts the sum is aligned.
    assign w_cat      = {w_sum, acc_q};
    assign w_acc_next = w_cat[WIDTH+DIGIT-1:DIGIT];
    // On the final digit, w_carry[DIGIT-1] is the carry into bit WIDTH-1.
    assign w_ov       = w_carry[DIGIT] ^ w_carry[DIGIT-1];

`ifdef ADDSUB_SAT_EN
    always_comb begin
        w_final = w_acc_next;
        if (sat_q && w_ov) begin
            // A wrapped MSB of 1 means the true result was too positive.
            w_final = w_acc_next[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                          : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end
`else
    logic w_unused_sat;
    assign w_unused_sat = sat_q;
    assign w_final      = w_acc_next;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sat_d   = sat_q;
        acc_d   = acc_q;
        done_d  = 1'b0;
        s_d     = s_q;
        co_d    = co_q;
        ov_d    = ov_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i ^ {WIDTH{sub_i}};
                    carry_d = ci_i ^ sub_i;
                    sat_d   = sat_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = w_carry[DIGIT];
                acc_d   = w_acc_next;
                cnt_d   = cnt_q + c_CNT_W'(1);
                if (cnt_q == c_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    s_d     = w_final;
                    co_d    = w_carry[DIGIT];
                    ov_d    = w_ov;
                    zero_d  = (w_final == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sat_q   <= 1'b0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sat_q   <= sat_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
            zero_q  <= zero_d;
        end
    end

    assign busy_o = (state_q == S_RUN);
    assign done_o = done_q;
    assign s_o    = s_q;
    assign co_o   = co_q;
    assign ov_o   = ov_q;
    assign zero_o = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_addsub_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_serial
//  Description : Scoreboard bench for addsub_serial. Three instances with
//                DIGIT = 4, 16 and 1 (WIDTH = 16). Expected results are
//                queued when a start is driven and compared on done.
//                Honours ADDSUB_SAT_EN in its reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_serial;
    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic        zero;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_v [3];
    logic [15:0] a_v     [3];
    logic [15:0] b_v     [3];
    logic        ci_v    [3];
    logic        sub_v   [3];
    logic        sat_v   [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic [15:0] s_v     [3];
    logic        co_v    [3];
    logic        ov_v    [3];
    logic        zero_v  [3];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int D = (gi == 0) ? 4 : ((gi == 1) ? 16 : 1);
        addsub_serial #(.WIDTH(16), .DIGIT(D)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start_i (start_v[gi]),
            .a_i     (a_v[gi]),
            .b_i     (b_v[gi]),
            .ci_i    (ci_v[gi]),
            .sub_i   (sub_v[gi]),
            .sat_i   (sat_v[gi]),
            .busy_o  (busy_v[gi]),
            .done_o  (done_v[gi]),
            .s_o     (s_v[gi]),
            .co_o    (co_v[gi]),
            .ov_o    (ov_v[gi]),
            .zero_o  (zero_v[gi])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ndig(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 1 : 16);
    endfunction

    // Reference: plain 17-bit arithmetic, carry into MSB from a 15-bit sum.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic sub, input logic sat);
        exp_t        e;
        logic [15:0] bv;
        logic        cin;
        logic [16:0] full;
        logic [15:0] low;
        bv   = sub ? ~b : b;
        cin  = ci ^ sub;
        full = {1'b0, a} + {1'b0, bv} + {16'd0, cin};
        low  = {1'b0, a[14:0]} + {1'b0, bv[14:0]} + {15'd0, cin};
        e.s  = full[15:0];
        e.co = full[16];
        e.ov = full[16] ^ low[15];
`ifdef ADDSUB_SAT_EN
        if (sat && e.ov) e.s = e.s[15] ? 16'h7FFF : 16'h8000;
`else
        if (sat && 1'b0) e.s = 16'h0;
`endif
        e.zero = (e.s == 16'h0);
        e.cyc  = 0;
        return e;
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpush(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic qflush(input int k);
        case (k)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    // Monitor: compare each done against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        bit   found;
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (done_v[k]) begin
                    found = 1'b0;
                    case (k)
                        0: if (q0.size() > 0) begin e = q0.pop_front(); found = 1'b1; end
                        1: if (q1.size() > 0) begin e = q1.pop_front(); found = 1'b1; end
                        default: if (q2.size() > 0) begin e = q2.pop_front(); found = 1'b1; end
                    endcase
                    if (!found) begin
                        check($sformatf("spurious_done[%0d]", k), 32'd1, 32'd0);
                    end else begin
                        check($sformatf("s[%0d]", k),       {16'd0, s_v[k]}, {16'd0, e.s});
                        check($sformatf("co[%0d]", k),      {31'd0, co_v[k]}, {31'd0, e.co});
                        check($sformatf("ov[%0d]", k),      {31'd0, ov_v[k]}, {31'd0, e.ov});
                        check($sformatf("zero[%0d]", k),    {31'd0, zero_v[k]}, {31'd0, e.zero});
                        check($sformatf("latency[%0d]", k), cyc, e.cyc);
                        check($sformatf("busy_at_done[%0d]", k), {31'd0, busy_v[k]}, 32'd0);
                    end
                end
            end
        end
    end

    // Drive one start request; when sync=0 the caller is already at a negedge.
    task automatic drive_start(input int k, input logic [15:0] a, input logic [15:0] b,
                               input logic ci, input logic sub, input logic sat,
                               input bit accept, input bit sync);
        exp_t e;
        if (sync) @(negedge clk);
        a_v[k]     = a;
        b_v[k]     = b;
        ci_v[k]    = ci;
        sub_v[k]   = sub;
        sat_v[k]   = sat;
        start_v[k] = 1'b1;
        if (accept) begin
            e     = model(a, b, ci, sub, sat);
            e.cyc = cyc + 1 + ndig(k);
            qpush(k, e);
        end
        @(negedge clk);
        start_v[k] = 1'b0;
        a_v[k]     = 16'($urandom);
        b_v[k]     = 16'($urandom);
        ci_v[k]    = 1'($urandom);
        sub_v[k]   = 1'($urandom);
        sat_v[k]   = 1'($urandom);
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (qsize(k) != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (qsize(k) != 0) begin
            check($sformatf("timeout[%0d]", k), 32'd0, 32'd1);
            qflush(k);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, {31'd0, busy_v[0]}, 32'd0);
        check({tag, "_done"}, {31'd0, done_v[0]}, 32'd0);
        check({tag, "_s"},    {16'd0, s_v[0]},    32'd0);
        check({tag, "_co"},   {31'd0, co_v[0]},   32'd0);
        check({tag, "_ov"},   {31'd0, ov_v[0]},   32'd0);
        check({tag, "_zero"}, {31'd0, zero_v[0]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0;
            ci_v[k] = 1'b0; sub_v[k] = 1'b0; sat_v[k] = 1'b0;
        end
        #1;
        check_cleared("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_cleared("after_release");

        // Directed cases on the DIGIT=4 instance.
        drive_start(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); wait_idle(0);
        drive_start(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1); wait_idle(0);
        drive_start(0, 16'h0010, 16'h0010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1); wait_idle(0);
        drive_start(0, 16'h0010, 16'h0010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); wait_idle(0);
        drive_start(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); wait_idle(0);
        drive_start(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1); wait_idle(0);

        // Start while busy is ignored.
        drive_start(0, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive_start(0, 16'hAAAA, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_idle(0);

        // Start in the done cycle is accepted.
        drive_start(0, 16'h4321, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        n = 0;
        @(negedge clk);
        while (!done_v[0] && n < 20) begin @(negedge clk); n++; end
        check("done_seen", {31'd0, done_v[0]}, 32'd1);
        drive_start(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle(0);

        // Reset in the middle of RUN clears everything at once.
        drive_start(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1); wait_idle(0);
        drive_start(0, 16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_cleared("mid_run_reset");
        qflush(0);
        @(negedge clk);
        rst = 1'b0;
        drive_start(0, 16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); wait_idle(0);

        // Random sweep on all three digit widths.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 20; i++) begin
                drive_start(k, 16'($urandom), 16'($urandom), 1'($urandom),
                            1'($urandom), 1'($urandom), 1'b1, 1'b1);
                wait_idle(k);
            end
            drive_start(k, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            wait_idle(k);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
